// File: rtl/trng_out_buf.sv
// trng_out_buf: consumer end of the rngcore output handshake.
// Captures 128-bit post-processor words into a DEPTH-entry FIFO,
// acknowledges each capture with a one-cycle rngcore_rddone pulse and
// serves the buffered data as 32-bit reads (low word first).
// Ports:
//   clk, rstn                          clock, async active-low reset
//   rngcore_en                         capture enable
//   flush                              synchronous clear of FIFO and state
//   rngcore_dataout/_vld, rngcore_rddone  producer handshake
//   rd_req, rd_data, rd_vld            32-bit read port, 1-cycle latency
//   level, empty, full                 occupancy in 32-bit words / status
//   underflow, rep_err                 sticky error flags
// Optional build macro TRNG_OUT_HEALTH_EN: drop a word identical to the
// previous capture and raise rep_err (the word is still acknowledged).
module trng_out_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rngcore_en,
    input  logic          flush,
    input  logic [127:0]  rngcore_dataout,
    input  logic          rngcore_dataout_vld,
    output logic          rngcore_rddone,
    input  logic          rd_req,
    output logic [31:0]   rd_data,
    output logic          rd_vld,
    output logic [AW+2:0] level,
    output logic          empty,
    output logic          full,
    output logic          underflow,
    output logic          rep_err
);
    localparam int LW = AW + 3;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic {CAP_IDLE, CAP_ACK} cap_state_t;

    cap_state_t    r_state;
    logic [127:0]  r_mem [DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic [1:0]    r_idx;
    logic [LW-1:0] r_level;
    logic [31:0]   r_rd_data;
    logic          r_rd_vld, r_uflow;
    logic          w_full, w_empty, w_cap, w_dup, w_wr, w_rd;
    logic [127:0]  w_head;
    logic [31:0]   w_word;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_level == '0);
    // full comes from registered pointers, so a pop only frees space for the next cycle
    assign w_cap   = ~flush & (r_state == CAP_IDLE) & rngcore_en & rngcore_dataout_vld & ~w_full;
    assign w_wr    = w_cap & ~w_dup;
    assign w_rd    = rd_req & ~w_empty;
    assign w_head  = r_mem[r_rptr[AW-1:0]];
    assign w_word  = w_head[{r_idx, 5'd0} +: 32];

`ifdef TRNG_OUT_HEALTH_EN
    logic [127:0] r_last;
    logic         r_last_vld, r_rep_err;

    assign w_dup   = r_last_vld && (rngcore_dataout == r_last);
    assign rep_err = r_rep_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_rep_err  <= 1'b0;
        end else if (flush) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_rep_err  <= 1'b0;
        end else if (w_cap) begin
            r_last     <= rngcore_dataout;
            r_last_vld <= 1'b1;
            if (w_dup) r_rep_err <= 1'b1;
        end
    end
`else
    assign w_dup   = 1'b0;
    assign rep_err = 1'b0;
`endif

    // the ack is the state register itself, masked so a flush in that cycle drops it
    assign rngcore_rddone = (r_state == CAP_ACK) & ~flush;
    assign rd_data        = r_rd_data;
    assign rd_vld         = r_rd_vld;
    assign level          = r_level;
    assign empty          = w_empty;
    assign full           = w_full;
    assign underflow      = r_uflow;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= rngcore_dataout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= CAP_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_idx     <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_uflow   <= 1'b0;
        end else if (flush) begin
            r_state   <= CAP_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_idx     <= '0;
            r_level   <= '0;
            r_rd_vld  <= 1'b0;
            r_uflow   <= 1'b0;
        end else begin
            r_state  <= w_cap ? CAP_ACK : CAP_IDLE;
            r_rd_vld <= w_rd;
            r_level  <= r_level + (w_wr ? LW'(4) : LW'(0)) - (w_rd ? LW'(1) : LW'(0));
            if (w_wr) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd) begin
                r_rd_data <= w_word;
                r_idx     <= r_idx + 2'd1;
                if (r_idx == 2'd3) r_rptr <= r_rptr + PTR_ONE;
            end
            if (rd_req && w_empty) r_uflow <= 1'b1;
        end
    end
endmodule
